// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute and writeback over one shared ALU and one unified memory.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   op[6:0]             opcode field of the instruction register
//   Zero                ALU zero flag (qualifies the branch PC write)
//   mem_ready           memory completes the current request this cycle
//   mem_req, MemWrite   memory request / request is a store
//   AdrSrc              memory address select (0=PC, 1=Result)
//   IRWrite, PCWrite,
//   RegWrite            instruction register, PC and register file enables
//   ALUSrcA[1:0]        00=PC, 01=OldPC, 10=RD1
//   ALUSrcB[1:0]        00=RD2, 01=ImmExt, 10=const 4
//   ResultSrc[1:0]      00=ALUOut, 01=Data, 10=ALUResult
//   ALUOp[1:0]          00=add, 01=sub, 10=funct decode, 11=pass-B
//   mem_err             one-cycle pulse when the watchdog aborts an access
//   illegal_op          one-cycle pulse on an unsupported opcode in DECODE
//
// Build option: define LUI_EN to execute LUI (opcode 0110111) through a
// pass-B ALU state; without it that opcode is treated as illegal.

module multicycle_control_fsm #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic       mem_err,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXECR  = 4'd7,
        S_EXECI  = 4'd8,
        S_ALUWB  = 4'd9,
        S_BEQ    = 4'd10,
        S_JAL    = 4'd11,
        S_LUI    = 4'd12
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
`ifdef LUI_EN
    localparam logic [6:0] OP_LUI   = 7'b0110111;
`endif

    localparam logic [CNT_W-1:0] WLAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;

    logic mem_wait;
    logic timeout;
    logic pc_update;
    logic branch;

    // Only the three memory-facing states can stall on mem_ready.
    assign mem_wait = (state_q == S_FETCH) ||
                      (state_q == S_MEMRD) ||
                      (state_q == S_MEMWR);

    // A completing handshake in the last allowed cycle beats the abort.
    assign timeout = mem_wait && !mem_ready && (wcnt_q == WLAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUOp      = 2'b00;
        mem_err    = 1'b0;
        illegal_op = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite   = 1'b1;
                    pc_update = 1'b1;
                    state_d   = S_DECODE;
                end else if (timeout) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_DECODE: begin
                // ALU forms OldPC + imm here for branch/jump targets.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                unique case (op)
                    OP_LOAD,
                    OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE: state_d = S_EXECR;
                    OP_ITYPE: state_d = S_EXECI;
                    OP_BEQ:   state_d = S_BEQ;
                    OP_JAL:   state_d = S_JAL;
`ifdef LUI_EN
                    OP_LUI:   state_d = S_LUI;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                // op[5] separates stores (0100011) from loads (0000011).
                state_d = op[5] ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = S_FETCH;
            end

            S_MEMWR: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (timeout) begin
                    mem_err = 1'b1;
                    state_d = S_FETCH;
                end
            end

            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end

            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end

            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end

            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end

            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end

`ifdef LUI_EN
            S_LUI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 2'b11;
                state_d = S_ALUWB;
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Branch target is taken only when the compare produced zero.
    assign PCWrite = pc_update | (branch & Zero);

    // Wait counter runs only while stalled, and restarts on any state
    // change as well as on an abort (a FETCH retry keeps the same state).
    always_comb begin
        wcnt_d = '0;
        if (timeout) begin
            wcnt_d = '0;
        end else if (state_d != state_q) begin
            wcnt_d = '0;
        end else if (mem_wait && !mem_ready) begin
            wcnt_d = wcnt_q + CNT_W'(1);
        end
    end

endmodule
